// File: rtl/pe_fp16_tile_mac.sv
// Output-stationary FP16 systolic PE: forwards operands right/down, multiplies valid
// pairs, accumulates acc_len products per tile and hands each sum off via ready/valid.
module pe_fp16_tile_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_valid_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_valid_in,
  input  logic [LEN_WIDTH-1:0]  acc_len,
  input  logic                  clear_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_valid_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_valid_out,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  overrun
);

  // Float16Mul: round-to-nearest-even, subnormal inputs and results flush to zero.
  function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
    logic              sgn;
    logic [4:0]        ex, ey;
    logic [21:0]       p;
    logic [10:0]       m;
    logic              g, s;
    logic signed [7:0] e;
    logic [15:0]       r;
    sgn = x[15] ^ y[15];
    ex  = x[14:10];
    ey  = y[14:10];
    p   = {1'b1, x[9:0]} * {1'b1, y[9:0]};
    e   = $signed({3'b000, ex}) + $signed({3'b000, ey}) - 8'sd15;
    if (p[21]) begin
      m = {1'b0, p[20:11]};
      g = p[10];
      s = |p[9:0];
      e = e + 8'sd1;
    end else begin
      m = {1'b0, p[19:10]};
      g = p[9];
      s = |p[8:0];
    end
    if (g & (s | m[0])) m = m + 11'd1;
    if (m[10]) begin
      m = 11'd0;
      e = e + 8'sd1;
    end
    if (e >= 8'sd31)     r = {sgn, 5'h1f, 10'h000};
    else if (e <= 8'sd0) r = {sgn, 15'h0000};
    else                 r = {sgn, e[4:0], m[9:0]};
    if ((ex == 5'h1f && x[9:0] != 10'h0) || (ey == 5'h1f && y[9:0] != 10'h0) ||
        ((ex == 5'h1f || ey == 5'h1f) && (ex == 5'h0 || ey == 5'h0)))
      r = 16'h7e00;
    else if (ex == 5'h1f || ey == 5'h1f)
      r = {sgn, 5'h1f, 10'h000};
    else if (ex == 5'h0 || ey == 5'h0)
      r = {sgn, 15'h0000};
    return r;
  endfunction

  // Float16Add: align with sticky bit, normalize, round-to-nearest-even.
  function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0]       big, sml, r;
    logic [4:0]        d;
    logic [24:0]       bigv, smlv, sh, sum;
    logic              lost, g, s, st;
    logic [10:0]       m;
    logic signed [7:0] e;
    if (x[14:0] >= y[14:0]) begin
      big = x; sml = y;
    end else begin
      big = y; sml = x;
    end
    d    = big[14:10] - sml[14:10];
    bigv = {2'b01, big[9:0], 13'h0};
    smlv = {2'b01, sml[9:0], 13'h0};
    sh   = smlv >> d;
    lost = (sh << d) != smlv;
    sh[0] = sh[0] | lost;
    sum  = (big[15] == sml[15]) ? bigv + sh : bigv - sh;
    e    = $signed({3'b000, big[14:10]});
    if (sum[24]) begin
      st  = sum[0];
      sum = sum >> 1;
      sum[0] = sum[0] | st;
      e = e + 8'sd1;
    end else begin
      for (int i = 0; i < 24; i++) begin
        if (!sum[23]) begin
          sum = sum << 1;
          e   = e - 8'sd1;
        end
      end
    end
    m = {1'b0, sum[22:13]};
    g = sum[12];
    s = |sum[11:0];
    if (g & (s | m[0])) m = m + 11'd1;
    if (m[10]) begin
      m = 11'd0;
      e = e + 8'sd1;
    end
    if (sum == 25'h0)        r = 16'h0000;
    else if (e >= 8'sd31)    r = {big[15], 5'h1f, 10'h000};
    else if (e <= 8'sd0)     r = {big[15], 15'h0000};
    else                     r = {big[15], e[4:0], m[9:0]};
    if ((x[14:10] == 5'h1f && x[9:0] != 10'h0) || (y[14:10] == 5'h1f && y[9:0] != 10'h0) ||
        (x[14:10] == 5'h1f && y[14:10] == 5'h1f && x[15] != y[15]))
      r = 16'h7e00;
    else if (x[14:10] == 5'h1f)
      r = x;
    else if (y[14:10] == 5'h1f)
      r = y;
    else if (x[14:10] == 5'h0)
      r = (y[14:10] == 5'h0) ? {x[15] & y[15], 15'h0000} : y;
    else if (y[14:10] == 5'h0)
      r = x;
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  a_v_q, a_v_d, b_v_q, b_v_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d;
  logic                  prod_v_q, prod_v_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, len_q, len_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  overrun_q, overrun_d;

  logic [LEN_WIDTH-1:0]  len_eff;
  logic [DATA_WIDTH-1:0] sum;
  logic                  tile_done;

  always_comb begin
    a_d      = a_in;
    a_v_d    = a_valid_in;
    b_d      = b_in;
    b_v_d    = b_valid_in;
    prod_d   = fp16_mul(a_q, b_q);
    prod_v_d = a_v_q & b_v_q & ~clear_in;

    // First product of a tile starts fresh and latches the tile length.
    if (cnt_q == '0) begin
      len_eff = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
      sum     = prod_q;
    end else begin
      len_eff = len_q;
      sum     = fp16_add(acc_q, prod_q);
    end
    tile_done = (cnt_q == len_eff - LEN_WIDTH'(1));

    acc_d          = acc_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;

    if (result_valid_q & result_ready) result_valid_d = 1'b0;

    if (clear_in) begin
      acc_d     = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (prod_v_q) begin
      if (cnt_q == '0) len_d = len_eff;
      if (tile_done) begin
        result_d       = sum;
        result_valid_d = 1'b1;
        if (result_valid_q & ~result_ready) overrun_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q            <= '0;
      a_v_q          <= 1'b0;
      b_q            <= '0;
      b_v_q          <= 1'b0;
      prod_q         <= '0;
      prod_v_q       <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      len_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      a_q            <= a_d;
      a_v_q          <= a_v_d;
      b_q            <= b_d;
      b_v_q          <= b_v_d;
      prod_q         <= prod_d;
      prod_v_q       <= prod_v_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign a_out        = a_q;
  assign a_valid_out  = a_v_q;
  assign b_out        = b_q;
  assign b_valid_out  = b_v_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/pe_fp16_tile_mac.md
# pe_fp16_tile_mac

Output-stationary FP16 processing element for the next-generation 2D systolic array. It forwards operands right/down with per-operand valid bits and performs a multiply-accumulate only when both operands are valid. It accumulates a programmable number of products per tile, then hands the finished sum off through a ready/valid result port while the next tile keeps accumulating. It is built from the existing Float16Mul and Float16Add cores and replaces the free-running always-accumulate PE.

## Interface
Parameters:
- DATA_WIDTH, 16, operand/result width; only 16 (FP16, Float16Mul/Float16Add format) is supported.
- LEN_WIDTH, 8, width of tile-length input and internal product counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; one clock; clears all state.
- a_in  in  DATA_WIDTH  row operand from left neighbour.
- a_valid_in  in  1  a_in qualifier.
- b_in  in  DATA_WIDTH  column operand from upper neighbour.
- b_valid_in  in  1  b_in qualifier.
- acc_len  in  LEN_WIDTH  products per tile; 0 treated as 1.
- clear_in  in  1  synchronous abort: discard partial sum and in-flight products.
- a_out / a_valid_out  out  DATA_WIDTH / 1  registered a_in / a_valid_in to right neighbour.
- b_out / b_valid_out  out  DATA_WIDTH / 1  registered b_in / b_valid_in to lower neighbour.
- result  out  DATA_WIDTH  completed tile sum.
- result_valid  out  1  result holds an unconsumed tile sum.
- result_ready  in  1  consumer accepts result when high with result_valid.
- overrun  out  1  sticky: an unconsumed result was overwritten.

## Operation
- Stage 0 (operand regs): every cycle a_reg<=a_in, a_v<=a_valid_in, b_reg<=b_in, b_v<=b_valid_in. Outputs a_out/b_out/valids are these regs. Forwarding is independent of MAC activity.
- Stage 1 (product reg): prod<=Float16Mul(a_reg,b_reg); prod_v<=a_v&b_v.
- Stage 2 (accumulate), when prod_v:
  - if cnt==0: latch len_q<=max(acc_len,1); sum=prod (no add with stale acc).
  - else sum=Float16Add(acc,prod).
  - if cnt==len_q-1 (using the newly latched value when cnt==0): result<=sum, result_valid<=1, acc<=0, cnt<=0.
  - else acc<=sum, cnt<=cnt+1.
- acc_len is sampled only at the first product of a tile; changes mid-tile have no effect.
- Result handshake: transfer when result_valid&result_ready → result_valid<=0 unless a new sum completes in the same cycle, in which case result loads the new sum and result_valid stays 1 with no overrun.
- Overrun: a new sum completes while result_valid=1 and result_ready=0 → result overwritten, overrun<=1. Overrun is cleared only by reset or clear_in.
- clear_in: acc<=0, cnt<=0, prod_v<=0, overrun<=0. Any product in flight this cycle is discarded. Stage-0 forwarding regs and result/result_valid are unaffected. clear_in has priority over accumulate.
- reset: all registers 0. Outputs after reset: a_out=b_out=0, valids=0, result=0, result_valid=0, overrun=0.
- No pipeline stall. Upstream is responsible for skewing a/b so that pairs align.

## Timing
- Forwarding latency 1 cycle: a_in at edge n appears on a_out after edge n.
- MAC latency: pair captured at edge n; product at edge n+1; accumulate/result at edge n+2.
- result_valid rises after edge n+2 for the last pair of a tile, i.e. 3 edges after presentation.
- Back-to-back tiles have zero bubble: the first product of tile k+1 may arrive in the cycle right after the completion of tile k.
- Throughput: one MAC per cycle.
- Float16Mul and Float16Add are combinational within their stage. The accumulator feedback path is a single cycle.

## Test plan
- Reset: hold reset 2 cycles with random inputs → all outputs 0; on the first post-reset cycle a_out=0.
- Single tile, acc_len=2: pairs (3C00,4000) then (4000,4200), i.e. 1×2 then 2×3, on consecutive cycles → result=4800 (8.0) with result_valid asserted 3 edges after the second pair; a_out/b_out echo each pair 1 cycle late.
- Valid gating: a_valid=1, b_valid=0 for 3 cycles, then both valid (3C00,3C00) with acc_len=1 → exactly one result, 3C00; no accumulation of the invalid cycles.
- Back-to-back tiles with result_ready=0: acc_len=1, pairs (4000,4000) then (4200,4000) → result 4400 then 4600, overrun=1. Repeat with result_ready=1 on the second completion → overrun stays 0.
- clear_in mid-tile: acc_len=3, two pairs of (3C00,3C00), clear_in, then three pairs of (4000,3C00) → result=4600 (6.0); no result between the two bursts.
- acc_len change mid-tile: start with acc_len=2, switch to 4 after the first pair → the tile still completes after 2 products; the next tile uses 4.
